// File: rtl/rs485_tx_dir_ctrl_if.sv
// rtl/rs485_tx_dir_ctrl_if.sv - byte stream handshake into the RS-485 transmitter
interface rs485_tx_dir_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] s_tdata;
    logic                 s_tvalid;
    logic                 s_tready;

    modport master (output s_tdata, output s_tvalid, input s_tready);
    modport slave  (input s_tdata, input s_tvalid, output s_tready);
endinterface

// File: rtl/rs485_tx_dir_ctrl.sv
// rtl/rs485_tx_dir_ctrl.sv - UART-framed RS-485 transmitter with DE/RE direction control
module rs485_tx_dir_ctrl #(
    parameter int    CLK_DIV         = 868,
    parameter int    DATA_BITS       = 8,
    parameter string PARITY          = "None",
    parameter int    STOP_BITS       = 1,
    parameter int    PRE_GUARD_BITS  = 1,
    parameter int    POST_GUARD_BITS = 1,
    parameter bit    RX_ECHO         = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    rs485_tx_dir_ctrl_if.slave        stream,
    output logic                      tx_busy,
    output logic                      ser_DI,
    output logic                      ser_DE,
    output logic                      ser_RE,
    input  logic                      ser_RO,
    output logic                      rx_line
);
    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam bit            HAS_PAR  = (PARITY != "None");
    localparam bit            ODD_PAR  = (PARITY == "Odd");

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_START, S_DATA, S_PAR, S_STOP, S_POST
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [7:0]           idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 par_q, par_n;
    logic [7:0]           bit_len;
    logic                 bit_end, last_bit, accept;
    logic                 di_d, de_d, re_d, busy_d, rdy_d;

    assign accept   = stream.s_tvalid && stream.s_tready;
    assign bit_end  = (cnt == CNT_LAST);
    assign last_bit = (idx == bit_len - 8'd1);
    assign rx_line  = ser_RE ? 1'b1 : ser_RO;

    // Number of bit-times the current state lasts.
    always_comb begin
        case (state)
            S_PRE:   bit_len = 8'(PRE_GUARD_BITS);
            S_DATA:  bit_len = 8'(DATA_BITS);
            S_STOP:  bit_len = 8'(STOP_BITS);
            S_POST:  bit_len = 8'(POST_GUARD_BITS);
            default: bit_len = 8'd1;
        endcase
    end

    // Next state, bit timer, bit index and latched byte; a byte accepted in the last STOP cycle chains straight to START.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        par_n   = par_q;
        if (state != S_IDLE) begin
            if (bit_end) begin
                cnt_n = '0;
                idx_n = last_bit ? 8'd0 : idx + 8'd1;
                if (state == S_DATA) sh_n = sh >> 1;
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end
        if (accept) begin
            sh_n  = stream.s_tdata;
            par_n = (^stream.s_tdata) ^ ODD_PAR;
            cnt_n = '0;
            idx_n = 8'd0;
        end
        if (state == S_IDLE) begin
            if (accept) state_n = (PRE_GUARD_BITS > 0) ? S_PRE : S_START;
        end else if (bit_end && last_bit) begin
            case (state)
                S_PRE:   state_n = S_START;
                S_START: state_n = S_DATA;
                S_DATA:  state_n = HAS_PAR ? S_PAR : S_STOP;
                S_PAR:   state_n = S_STOP;
                S_STOP:  state_n = accept ? S_START : ((POST_GUARD_BITS > 0) ? S_POST : S_IDLE);
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Output values for the coming cycle, derived from where the FSM is heading so they can be registered.
    always_comb begin
        de_d   = (state_n != S_IDLE);
        busy_d = de_d;
        re_d   = RX_ECHO ? 1'b0 : de_d;
        rdy_d  = (state_n == S_IDLE) ||
                 (state_n == S_STOP && cnt_n == CNT_LAST && idx_n == 8'(STOP_BITS - 1));
        case (state_n)
            S_START: di_d = 1'b0;
            S_DATA:  di_d = sh_n[0];
            S_PAR:   di_d = par_n;
            default: di_d = 1'b1;
        endcase
    end

    // State and registered outputs; reset drops the driver immediately and leaves the line idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            idx             <= 8'd0;
            sh              <= '0;
            par_q           <= 1'b0;
            ser_DI          <= 1'b1;
            ser_DE          <= 1'b0;
            ser_RE          <= 1'b0;
            tx_busy         <= 1'b0;
            stream.s_tready <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            idx             <= idx_n;
            sh              <= sh_n;
            par_q           <= par_n;
            ser_DI          <= di_d;
            ser_DE          <= de_d;
            ser_RE          <= re_d;
            tx_busy         <= busy_d;
            stream.s_tready <= rdy_d;
        end
    end
endmodule
